// File: rtl/cpu_pkg.sv
// Shared encodings for the ALU sequencer: unit opcodes, request opcodes,
// status register bit positions, reset value and the sequencer state type.
package cpu_pkg;

    // Opcodes driven to the arithmetic unit
    localparam logic [2:0] ALU_ADR0 = 3'b000;
    localparam logic [2:0] ALU_ADR1 = 3'b001;
    localparam logic [2:0] ALU_ADC  = 3'b010;
    localparam logic [2:0] ALU_LD   = 3'b011;
    localparam logic [2:0] ALU_ASL  = 3'b100;
    localparam logic [2:0] ALU_BCC  = 3'b101;
    localparam logic [2:0] OP_IDLE  = 3'b111;

    // Request opcodes presented by the decoder
    localparam logic [2:0] REQ_NOP = 3'b000;
    localparam logic [2:0] REQ_ADC = 3'b010;
    localparam logic [2:0] REQ_LD  = 3'b011;
    localparam logic [2:0] REQ_ASL = 3'b100;
    localparam logic [2:0] REQ_BCC = 3'b101;
    localparam logic [2:0] REQ_CLC = 3'b110;
    localparam logic [2:0] REQ_SEC = 3'b111;

    // Status register layout NV1BDIZC
    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_I = 2;
    localparam int P_D = 3;
    localparam int P_B = 4;
    localparam int P_U = 5;
    localparam int P_V = 6;
    localparam int P_N = 7;

    localparam logic [7:0] P_RESET = 8'h20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_BR_TEST,
        S_BR_LO,
        S_BR_HI,
        S_DONE
    } seq_state_t;

    // Maps a data request onto the unit opcode; anything without a unit
    // operation (NOP, CLC, SEC, undefined) idles the unit.
    function automatic logic [2:0] reqToAluOp(input logic [2:0] op);
        case (op)
            REQ_ADC: reqToAluOp = ALU_ADC;
            REQ_LD:  reqToAluOp = ALU_LD;
            REQ_ASL: reqToAluOp = ALU_ASL;
            REQ_BCC: reqToAluOp = ALU_BCC;
            default: reqToAluOp = OP_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bus between the sequencer (master) and the arithmetic unit (slave).
interface alu_sequencer_if;

    logic [2:0] alu_opcode;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] flags_in;
    logic [7:0] alu_out;
    logic [7:0] flags_out;
    logic [7:0] flags_ena;
    logic       branch_valid;

    modport master (
        output alu_opcode, alu_a, alu_b, flags_in,
        input  alu_out, flags_out, flags_ena, branch_valid
    );

    modport slave (
        input  alu_opcode, alu_a, alu_b, flags_in,
        output alu_out, flags_out, flags_ena, branch_valid
    );

endinterface

// File: rtl/alu_sequencer_status_reg.sv
// Processor status register P: masked merge of unit flags, explicit carry
// set/clear, and bit 5 forced to 1 on every update.
module status_reg
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_mergeEn,
    input  logic [7:0] i_flagsOut,
    input  logic [7:0] i_flagsEna,
    input  logic       i_setC,
    input  logic       i_clrC,
    output logic [7:0] o_p
);

    logic [7:0] r_p;
    logic [7:0] w_next;

    // Next P: enabled flag bits come from the unit, the rest are kept
    always_comb begin
        w_next = r_p;
        if (i_mergeEn) begin
            w_next = (r_p & ~i_flagsEna) | (i_flagsOut & i_flagsEna);
        end
        if (i_setC) begin
            w_next[P_C] = 1'b1;
        end
        if (i_clrC) begin
            w_next[P_C] = 1'b0;
        end
        w_next[P_U] = 1'b1;
    end

    // P register update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p <= P_RESET;
        end else begin
            r_p <= w_next;
        end
    end

    assign o_p = r_p;

endmodule

// File: rtl/alu_sequencer.sv
// Issuing/consuming side of the arithmetic unit. Runs data ops in one EXEC
// cycle and relative branches as BCC test -> ADR0 -> ADR1.
// Optional build macro ALU_SEQ_FLAG_CTRL_EN: CLC/SEC clear/set carry
// directly; without it they behave as NOP.
module alu_sequencer
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_op,
    input  logic [7:0]             req_a,
    input  logic [7:0]             req_b,
    input  logic [15:0]            pc_in,
    alu_sequencer_if.master        aluBus,
    output logic                   res_valid,
    output logic [7:0]             res_data,
    output logic                   pc_load,
    output logic [15:0]            pc_out,
    output logic                   page_cross,
    output logic [7:0]             p_reg
);

`ifdef ALU_SEQ_FLAG_CTRL_EN
    localparam bit C_FLAG_CTRL_EN = 1'b1;
`else
    localparam bit C_FLAG_CTRL_EN = 1'b0;
`endif

    seq_state_t  r_state;
    logic [2:0]  r_op;
    logic [15:0] r_pcIn;
    logic [7:0]  r_offset;
    logic [2:0]  r_aluOpcode;
    logic [7:0]  r_aluA;
    logic [7:0]  r_aluB;
    logic        r_reqReady;
    logic        r_resValid;
    logic [7:0]  r_resData;
    logic        r_pcLoad;
    logic [15:0] r_pcOut;
    logic        r_pageCross;

    logic        w_isFlagOp;
    logic        w_mergeEn;
    logic        w_setC;
    logic        w_clrC;

    assign w_isFlagOp = C_FLAG_CTRL_EN && ((r_op == REQ_CLC) || (r_op == REQ_SEC));
    assign w_mergeEn  = (r_state == S_EXEC) && !w_isFlagOp;
    assign w_setC     = (r_state == S_EXEC) && w_isFlagOp && (r_op == REQ_SEC);
    assign w_clrC     = (r_state == S_EXEC) && w_isFlagOp && (r_op == REQ_CLC);

    status_reg u_statusReg (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_mergeEn  (w_mergeEn),
        .i_flagsOut (aluBus.flags_out),
        .i_flagsEna (aluBus.flags_ena),
        .i_setC     (w_setC),
        .i_clrC     (w_clrC),
        .o_p        (p_reg)
    );

    // Sequencer FSM; unit-side outputs are registered one state ahead so
    // they are stable throughout the state that uses them
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_op        <= REQ_NOP;
            r_pcIn      <= 16'h0000;
            r_offset    <= 8'h00;
            r_aluOpcode <= OP_IDLE;
            r_aluA      <= 8'h00;
            r_aluB      <= 8'h00;
            r_reqReady  <= 1'b1;
            r_resValid  <= 1'b0;
            r_resData   <= 8'h00;
            r_pcLoad    <= 1'b0;
            r_pcOut     <= 16'h0000;
            r_pageCross <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op       <= req_op;
                        r_pcIn     <= pc_in;
                        r_offset   <= req_a;
                        r_reqReady <= 1'b0;
                        if (req_op == REQ_BCC) begin
                            r_state     <= S_BR_TEST;
                            r_aluOpcode <= ALU_BCC;
                            r_aluA      <= 8'h00;
                            r_aluB      <= 8'h00;
                        end else begin
                            r_state     <= S_EXEC;
                            r_aluOpcode <= reqToAluOp(req_op);
                            r_aluA      <= req_a;
                            r_aluB      <= req_b;
                        end
                    end
                end
                S_EXEC: begin
                    r_resData   <= w_isFlagOp ? 8'h00 : aluBus.alu_out;
                    r_aluOpcode <= OP_IDLE;
                    r_aluA      <= 8'h00;
                    r_aluB      <= 8'h00;
                    r_resValid  <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_BR_TEST: begin
                    if (aluBus.branch_valid) begin
                        r_aluOpcode <= ALU_ADR0;
                        r_aluA      <= r_pcIn[7:0];
                        r_aluB      <= r_offset;
                        r_state     <= S_BR_LO;
                    end else begin
                        r_aluOpcode <= OP_IDLE;
                        r_resData   <= 8'h00;
                        r_pcLoad    <= 1'b0;
                        r_pageCross <= 1'b0;
                        r_resValid  <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_BR_LO: begin
                    r_pcOut[7:0] <= aluBus.alu_out;
                    r_aluOpcode  <= ALU_ADR1;
                    r_aluA       <= 8'h00;
                    r_aluB       <= r_offset[7] ? (r_pcIn[15:8] - 8'd1) : r_pcIn[15:8];
                    r_state      <= S_BR_HI;
                end
                S_BR_HI: begin
                    r_pcOut[15:8] <= aluBus.alu_out;
                    r_pageCross   <= (aluBus.alu_out != r_pcIn[15:8]);
                    r_pcLoad      <= 1'b1;
                    r_resData     <= 8'h00;
                    r_aluOpcode   <= OP_IDLE;
                    r_aluA        <= 8'h00;
                    r_aluB        <= 8'h00;
                    r_resValid    <= 1'b1;
                    r_state       <= S_DONE;
                end
                S_DONE: begin
                    r_resValid <= 1'b0;
                    r_pcLoad   <= 1'b0;
                    r_reqReady <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_aluOpcode <= OP_IDLE;
                    r_reqReady  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready         = r_reqReady;
    assign aluBus.alu_opcode = r_aluOpcode;
    assign aluBus.alu_a      = r_aluA;
    assign aluBus.alu_b      = r_aluB;
    assign aluBus.flags_in   = p_reg;
    assign res_valid         = r_resValid;
    assign res_data          = r_resData;
    assign pc_load           = r_pcLoad;
    assign pc_out            = r_pcOut;
    assign page_cross        = r_pageCross;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a small arithmetic-unit model on
// the slave side of the bus. Expected results are hand-computed constants.
module tb_alu_sequencer;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic [15:0] pc_in;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        pc_load;
    logic [15:0] pc_out;
    logic        page_cross;
    logic [7:0]  p_reg;

    alu_sequencer_if aluBus ();

    alu_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .pc_in      (pc_in),
        .aluBus     (aluBus),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .pc_load    (pc_load),
        .pc_out     (pc_out),
        .page_cross (page_cross),
        .p_reg      (p_reg)
    );

`ifdef ALU_SEQ_FLAG_CTRL_EN
    localparam logic [7:0] P_AFTER_SEC = 8'h21;
`else
    localparam logic [7:0] P_AFTER_SEC = 8'h20;
`endif

    typedef struct {
        logic [7:0]  data;
        logic [7:0]  p;
        logic        pcLoad;
        logic [15:0] pc;
        logic        pcross;
        int          lat;
        int          issue;
        bit          chkData;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   nChecks = 0;
    int   nMis = 0;

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Arithmetic unit model: combinational result, registered ADR0 carry
    logic [8:0] uSum;
    logic [8:0] adr0Sum;
    logic       uCarry;

    assign adr0Sum = {1'b0, aluBus.alu_a} + {1'b0, aluBus.alu_b};

    always_comb begin
        uSum                = 9'h000;
        aluBus.alu_out      = 8'h00;
        aluBus.flags_out    = 8'h00;
        aluBus.flags_ena    = 8'h00;
        aluBus.branch_valid = 1'b0;
        case (aluBus.alu_opcode)
            3'b000: begin
                aluBus.alu_out      = adr0Sum[7:0];
                aluBus.flags_out[0] = adr0Sum[8];
            end
            3'b001: begin
                uSum           = {1'b0, aluBus.alu_a} + {1'b0, aluBus.alu_b} + {8'h00, uCarry};
                aluBus.alu_out = uSum[7:0];
            end
            3'b010: begin
                uSum                = {1'b0, aluBus.alu_a} + {1'b0, aluBus.alu_b} + {8'h00, aluBus.flags_in[0]};
                aluBus.alu_out      = uSum[7:0];
                aluBus.flags_out[0] = uSum[8];
                aluBus.flags_out[1] = (uSum[7:0] == 8'h00);
                aluBus.flags_out[6] = (aluBus.alu_a[7] == aluBus.alu_b[7]) && (uSum[7] != aluBus.alu_a[7]);
                aluBus.flags_out[7] = uSum[7];
                aluBus.flags_ena    = 8'hC3;
            end
            3'b011: begin
                aluBus.alu_out      = aluBus.alu_a;
                aluBus.flags_out[1] = (aluBus.alu_a == 8'h00);
                aluBus.flags_out[7] = aluBus.alu_a[7];
                aluBus.flags_ena    = 8'h82;
            end
            3'b100: begin
                aluBus.alu_out      = {aluBus.alu_a[6:0], 1'b0};
                aluBus.flags_out[0] = aluBus.alu_a[7];
                aluBus.flags_out[1] = (aluBus.alu_a[6:0] == 7'h00);
                aluBus.flags_out[7] = aluBus.alu_a[6];
                aluBus.flags_ena    = 8'h83;
            end
            3'b101: begin
                aluBus.branch_valid = ~aluBus.flags_in[0];
            end
            default: begin
                aluBus.alu_out = 8'h00;
            end
        endcase
    end

    // Unit carry register, loaded by ADR0 and consumed by the following ADR1
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uCarry <= 1'b0;
        end else if (aluBus.alu_opcode == 3'b000) begin
            uCarry <= adr0Sum[8];
        end
    end

    // Single comparison with failure reporting
    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop expected result whenever the DUT completes
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && res_valid) begin
            if (sb.size() == 0) begin
                nChecks++;
                nMis++;
                $display("[TB] FAIL unexpected_res_valid: got 1, expected 0 at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                checkOutput("latency", 16'(cyc - e.issue), 16'(e.lat));
                checkOutput("p_reg", {8'h00, p_reg}, {8'h00, e.p});
                checkOutput("pc_load", {15'h0, pc_load}, {15'h0, e.pcLoad});
                if (e.chkData) checkOutput("res_data", {8'h00, res_data}, {8'h00, e.data});
                if (e.pcLoad) begin
                    checkOutput("pc_out", pc_out, e.pc);
                    checkOutput("page_cross", {15'h0, page_cross}, {15'h0, e.pcross});
                end
            end
        end
    end

    // Issue one request once the DUT is ready; inputs are scrambled after acceptance
    task automatic applyStimulus(
        input logic [2:0]  op,
        input logic [7:0]  a,
        input logic [7:0]  b,
        input logic [15:0] pc,
        input logic [7:0]  expData,
        input logic [7:0]  expP,
        input logic        expPcLoad,
        input logic [15:0] expPc,
        input logic        expPcross,
        input int          expLat,
        input bit          chkData,
        input bit          push,
        output int         issueCyc
    );
        exp_t e;
        int waitCnt;
        waitCnt = 0;
        @(negedge clk);
        while (!req_ready && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!req_ready) begin
            nChecks++;
            nMis++;
            $display("[TB] FAIL ready_timeout: got req_ready=0, expected 1 within 100 cycles");
        end
        req_op    = op;
        req_a     = a;
        req_b     = b;
        pc_in     = pc;
        req_valid = 1'b1;
        issueCyc  = cyc;
        if (push) begin
            e.data = expData; e.p = expP; e.pcLoad = expPcLoad; e.pc = expPc;
            e.pcross = expPcross; e.lat = expLat; e.issue = cyc; e.chkData = chkData;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = 8'($urandom);
        req_b     = 8'($urandom);
        pc_in     = 16'($urandom);
        req_op    = 3'b101;
    endtask

    initial begin
        int issue;
        int guard;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'b000;
        req_a     = 8'h00;
        req_b     = 8'h00;
        pc_in     = 16'h0000;
        #12;
        checkOutput("reset_p_reg", {8'h00, p_reg}, 16'h0020);
        checkOutput("reset_res_valid", {15'h0, res_valid}, 16'h0000);
        checkOutput("reset_res_data", {8'h00, res_data}, 16'h0000);
        checkOutput("reset_pc_out", pc_out, 16'h0000);
        checkOutput("reset_alu_opcode", {13'h0, aluBus.alu_opcode}, 16'h0007);
        checkOutput("reset_req_ready", {15'h0, req_ready}, 16'h0001);
        @(negedge clk);
        reset_n = 1'b1;

        //            op      a      b      pc        data   P      ld    pc        pcx   lat chk push
        applyStimulus(3'b010, 8'h50, 8'h50, 16'h0000, 8'hA0, 8'hE0, 1'b0, 16'h0000, 1'b0, 2, 1, 1, issue);
        applyStimulus(3'b100, 8'h80, 8'h00, 16'h0000, 8'h00, 8'h63, 1'b0, 16'h0000, 1'b0, 2, 1, 1, issue);
        applyStimulus(3'b010, 8'hFE, 8'h01, 16'h0000, 8'h00, 8'h23, 1'b0, 16'h0000, 1'b0, 2, 1, 1, issue);
        applyStimulus(3'b011, 8'h00, 8'h00, 16'h0000, 8'h00, 8'h23, 1'b0, 16'h0000, 1'b0, 2, 1, 1, issue);
        applyStimulus(3'b010, 8'h00, 8'h01, 16'h0000, 8'h02, 8'h20, 1'b0, 16'h0000, 1'b0, 2, 1, 1, issue);
        applyStimulus(3'b101, 8'h20, 8'h00, 16'h12F0, 8'h00, 8'h20, 1'b1, 16'h1310, 1'b1, 4, 0, 1, issue);
        applyStimulus(3'b101, 8'hF0, 8'h00, 16'h1205, 8'h00, 8'h20, 1'b1, 16'h11F5, 1'b1, 4, 0, 1, issue);
        applyStimulus(3'b101, 8'h20, 8'h00, 16'hFFF0, 8'h00, 8'h20, 1'b1, 16'h0010, 1'b1, 4, 0, 1, issue);
        applyStimulus(3'b101, 8'h05, 8'h00, 16'h1234, 8'h00, 8'h20, 1'b1, 16'h1239, 1'b0, 4, 0, 1, issue);
        applyStimulus(3'b000, 8'h55, 8'hAA, 16'h0000, 8'h00, 8'h20, 1'b0, 16'h0000, 1'b0, 2, 1, 1, issue);
        applyStimulus(3'b111, 8'h00, 8'h00, 16'h0000, 8'h00, P_AFTER_SEC, 1'b0, 16'h0000, 1'b0, 2, 1, 1, issue);
        applyStimulus(3'b110, 8'h00, 8'h00, 16'h0000, 8'h00, 8'h20, 1'b0, 16'h0000, 1'b0, 2, 1, 1, issue);
        applyStimulus(3'b100, 8'h80, 8'h00, 16'h0000, 8'h00, 8'h23, 1'b0, 16'h0000, 1'b0, 2, 1, 1, issue);
        applyStimulus(3'b101, 8'h10, 8'h00, 16'h1000, 8'h00, 8'h23, 1'b0, 16'h0000, 1'b0, 2, 1, 1, issue);
        applyStimulus(3'b010, 8'h00, 8'h00, 16'h0000, 8'h01, 8'h20, 1'b0, 16'h0000, 1'b0, 2, 1, 1, issue);

        // Taken branch interrupted by reset while in BR_HI
        applyStimulus(3'b101, 8'h20, 8'h00, 16'h12F0, 8'h00, 8'h20, 1'b0, 16'h0000, 1'b0, 4, 0, 0, issue);
        guard = 0;
        while (cyc != issue + 3 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_p_reg", {8'h00, p_reg}, 16'h0020);
        checkOutput("midreset_res_valid", {15'h0, res_valid}, 16'h0000);
        checkOutput("midreset_pc_load", {15'h0, pc_load}, 16'h0000);
        checkOutput("midreset_pc_out", pc_out, 16'h0000);
        checkOutput("midreset_page_cross", {15'h0, page_cross}, 16'h0000);
        checkOutput("midreset_alu_opcode", {13'h0, aluBus.alu_opcode}, 16'h0007);
        checkOutput("midreset_alu_b", {8'h00, aluBus.alu_b}, 16'h0000);
        checkOutput("midreset_req_ready", {15'h0, req_ready}, 16'h0001);
        @(negedge clk);
        reset_n = 1'b1;

        applyStimulus(3'b010, 8'h50, 8'h50, 16'h0000, 8'hA0, 8'hE0, 1'b0, 16'h0000, 1'b0, 2, 1, 1, issue);

        // Drain scoreboard with a bounded wait
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        if (sb.size() != 0) begin
            nChecks++;
            nMis++;
            $display("[TB] FAIL drain: got %0d pending results, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nMis);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Issuing and consuming side of the arithmetic unit interface. Accepts one decoded operation at a time and drives alu_opcode, alu_a and alu_b. Owns the processor status register P and merges the unit's flags_out under flags_ena. For relative branches, sequences BCC test → ADR0 → ADR1 to produce the 16-bit target PC and a page-cross indication.

Parameters:
P_RESET, 8'h20, status register value on reset; bit 5 always reads 1
OP_IDLE, 3'b111, alu_opcode driven when no operation is in flight; the unit returns zeros for it

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  operation request
req_ready  out  1  high only in IDLE; accept when req_valid & req_ready
req_op  in  3  000 NOP, 010 ADC, 011 LD, 100 ASL, 101 BCC, 110 CLC, 111 SEC; others behave as NOP
req_a  in  8  operand A, or branch offset (two's complement) for BCC
req_b  in  8  operand B (ADC only)
pc_in  in  16  PC of the following instruction, BCC only
alu_opcode  out  3  to arithmetic unit
alu_a  out  8  to arithmetic unit
alu_b  out  8  to arithmetic unit
flags_in  out  8  to arithmetic unit; always equals p_reg
alu_out  in  8  from arithmetic unit
flags_out  in  8  from arithmetic unit
flags_ena  in  8  from arithmetic unit
branch_valid  in  1  from arithmetic unit
res_valid  out  1  one-cycle completion pulse
res_data  out  8  result byte; held until the next completion
pc_load  out  1  qualifies pc_out; valid with res_valid
pc_out  out  16  branch target
page_cross  out  1  target high byte differs from pc_in high byte
p_reg  out  8  status register NV1BDIZC

Behaviour:
- Reset (asynchronous, any state): state=IDLE; p_reg=P_RESET; res_valid, res_data, pc_load, pc_out, page_cross = 0; alu_opcode=OP_IDLE; alu_a, alu_b = 0.
- States: IDLE, EXEC, BR_TEST, BR_LO, BR_HI, DONE.
- IDLE: capture the request on acceptance. Go to EXEC for ADC/LD/ASL/NOP/CLC/SEC, or to BR_TEST for BCC.
- EXEC:
  - Drive the opcode (NOP→OP_IDLE), alu_a=req_a, alu_b=req_b.
  - At the clock edge: res_data<=alu_out; p_reg<=(p_reg & ~flags_ena)|(flags_out & flags_ena), then force bit5=1.
  - Go to DONE.
- BR_TEST: drive 101 and sample branch_valid. If 0, go to DONE with pc_load=0 and res_data=0. If 1, go to BR_LO.
- BR_LO: drive ADR0 (000), alu_a=pc_in[7:0], alu_b=offset. Latch alu_out into pc_out[7:0] and flags_out[0] into the internal carry.
- BR_HI: drive ADR1 (001), alu_b = offset[7] ? pc_in[15:8]-1 : pc_in[15:8] (mod 256). The unit adds its own registered carry from BR_LO. Latch alu_out into pc_out[15:8]; set pc_load=1; page_cross = (alu_out != pc_in[15:8]).
- BR_LO and BR_HI are strictly consecutive cycles; the unit's carry register depends on it.
- Branch ops never modify p_reg. Flag merge happens only in EXEC.
- DONE: res_valid=1 for exactly one cycle, then IDLE.
- Latency from the accept edge T:
  - data/flag op: res_valid high in cycle T+2
  - branch not taken: T+2
  - branch taken: T+4
- No result backpressure. req_ready=0 in every state except IDLE. Requests outside IDLE are ignored.
- pc_in and operands are captured at acceptance; later input changes have no effect.
- Wrap-around: pc 16'hFFF0 with offset 8'h20 gives 16'h0010, page_cross=1.
- Outside EXEC/BR_*: alu_opcode=OP_IDLE, alu_a=alu_b=0.

Optional Feature:
ALU_SEQ_FLAG_CTRL_EN
- Defined: CLC/SEC complete in EXEC without using the unit's result. p_reg[0] is cleared/set, res_data=0.
- Undefined: 110/111 decode as NOP; p_reg is unchanged.

Decomposition:
- Shared package cpu_pkg:
  - alu_opcode encodings (ADR0, ADR1, ADC, LD, ASL, BCC, IDLE)
  - req_op encodings
  - P bit indices (C=0, Z=1, I=2, D=3, B=4, U=5, V=6, N=7)
  - P_RESET
  - state enum
- One natural sub-module: status_reg (masked merge, bit5 force, set/clear inputs).

Test Plan:
- P=0x20; ADC a=0x50, b=0x50 → res_data=0xA0, p_reg=0xE0; res_valid at T+2.
- P with C=1; ADC a=0xFE, b=0x01 → res_data=0x00, p_reg=0x23.
- LD a=0x00 with C=1 → res_data=0x00, p_reg=0x23 (Z set, C preserved).
- BCC with C=0:
  - pc_in=0x12F0, offset=0x20 → pc_out=0x1310, page_cross=1, pc_load=1 at T+4.
  - pc_in=0x1205, offset=0xF0 → pc_out=0x11F5, page_cross=1.
- BCC with C=1 → pc_load=0, res_valid at T+2, p_reg unchanged.
- Assert reset_n low during BR_HI → immediate IDLE, p_reg=0x20, all outputs 0. The next ADC completes normally.
